// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter: grant encoding,
// the writeback request record, and default data/address widths.
package wb_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FPU  = 2'd2
    } grant_e;

    // Default-width writeback request; the arbiter declares its own copy sized by its parameters
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
        logic                  isFloat;
    } wbRequest_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding FPU results until they win the write port.
// The caller guarantees push only when not full and pop only when not empty.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;

    // Storage carries no reset; only pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage and
// buffered FPU results; an age counter forces a stall so FPU results cannot starve.
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            pipe_valid,
    input  logic [ADDR_W-1:0]               pipe_rd,
    input  logic [DATA_W-1:0]               pipe_data,
    input  logic                            pipe_is_float,
    output logic                            pipe_stall,

    input  logic                            fpu_valid,
    input  logic [ADDR_W-1:0]               fpu_rd,
    input  logic [DATA_W-1:0]               fpu_data,
    input  logic                            fpu_is_float,
    output logic                            fpu_ready,

    output logic [ADDR_W-1:0]               WA,
    output logic [DATA_W-1:0]               WB,
    output logic                            WE,
    output logic                            WEF,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fpu_pending
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int AW = $clog2(MAX_WAIT+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] MAXW_C  = AW'(MAX_WAIT);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              isFloat;
    } req_t;

    req_t          pipeReq;
    req_t          fpuReq;
    req_t          headReq;
    req_t          selReq;
    grant_e        grant;
    logic [CW-1:0] count;
    logic [AW-1:0] age;
    logic          fifoEmpty;
    logic          forceFpu;
    logic          push;
    logic          pop;

    assign pipeReq = '{rd: pipe_rd, data: pipe_data, isFloat: pipe_is_float};
    assign fpuReq  = '{rd: fpu_rd,  data: fpu_data,  isFloat: fpu_is_float};

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early
    assign fpu_ready   = !rst && (count < DEPTH_C);
    assign push        = fpu_valid && fpu_ready;
    assign pop         = (grant == GNT_FPU);
    assign fpu_pending = count;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(req_t))
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (fpuReq),
        .pop      (pop),
        .headData (headReq),
        .count    (count)
    );

    assign fifoEmpty  = (count == '0);
    assign forceFpu   = !rst && !fifoEmpty && (age >= MAXW_C);
    assign pipe_stall = forceFpu && pipe_valid;

    // Age counts cycles the head is denied; a pop or an empty FIFO restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (fifoEmpty || pop) begin
            age <= '0;
        end else if (age < MAXW_C) begin
            age <= age + AW'(1);
        end
    end

    always_comb begin
        grant  = GNT_NONE;
        selReq = '0;
        if (!rst) begin
            if (!fifoEmpty && (!pipe_valid || forceFpu)) begin
                grant = GNT_FPU;
            end else if (pipe_valid) begin
                grant = GNT_PIPE;
            end
        end
        unique case (grant)
            GNT_FPU:  selReq = headReq;
            GNT_PIPE: selReq = pipeReq;
            default:  selReq = '0;
        endcase
    end

    // Integer x0 writes still consume the grant but never assert the enable
    assign WA  = selReq.rd;
    assign WB  = selReq.data;
    assign WEF = (grant != GNT_NONE) && selReq.isFloat;
    assign WE  = (grant != GNT_NONE) && !selReq.isFloat && (selReq.rd != '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with default parameters
// (FIFO_DEPTH=2, MAX_WAIT=4, DATA_W=32, ADDR_W=5).
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_is_float;
    logic        pipe_stall;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        fpu_is_float;
    logic        fpu_ready;
    logic [4:0]  WA;
    logic [31:0] WB;
    logic        WE;
    logic        WEF;
    logic [1:0]  fpu_pending;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter #(
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4),
        .DATA_W     (32),
        .ADDR_W     (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .pipe_is_float (pipe_is_float),
        .pipe_stall    (pipe_stall),
        .fpu_valid     (fpu_valid),
        .fpu_rd        (fpu_rd),
        .fpu_data      (fpu_data),
        .fpu_is_float  (fpu_is_float),
        .fpu_ready     (fpu_ready),
        .WA            (WA),
        .WB            (WB),
        .WE            (WE),
        .WEF           (WEF),
        .fpu_pending   (fpu_pending)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                                 input logic pf, input logic fv, input logic [4:0] frd,
                                 input logic [31:0] fdata, input logic ff);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pdata; pipe_is_float = pf;
        fpu_valid  = fv; fpu_rd  = frd; fpu_data  = fdata; fpu_is_float  = ff;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        applyStimulus(1'b1, 5'd5, 32'h1111_1111, 1'b0, 1'b1, 5'd6, 32'h2222_2222, 1'b0);
        tick; settle;
        checks++; if (WE !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%0b exp=0", WE); end
        checks++; if (WEF !== 1'b0) begin failures++; $display("[TB] FAIL rst_wef got=%0b exp=0", WEF); end
        checks++; if (fpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0b exp=0", fpu_ready); end
        checks++; if (fpu_pending !== 2'd0) begin failures++; $display("[TB] FAIL rst_pending got=%0d exp=0", fpu_pending); end
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall got=%0b exp=0", pipe_stall); end
        checks++; if (WA !== 5'd0 || WB !== 32'd0) begin failures++; $display("[TB] FAIL rst_wa_wb got=%0h/%0h exp=0/0", WA, WB); end
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick; settle;
        checks++; if (fpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_ready got=%0b exp=1", fpu_ready); end
        checks++; if (fpu_pending !== 2'd0) begin failures++; $display("[TB] FAIL post_rst_pending got=%0d exp=0", fpu_pending); end
        tick;
    endtask

    task automatic test_pipe_write;
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (WA !== 5'd5) begin failures++; $display("[TB] FAIL pipe_wa got=%0d exp=5", WA); end
        checks++; if (WB !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL pipe_wb got=%0h exp=deadbeef", WB); end
        checks++; if (WE !== 1'b1 || WEF !== 1'b0) begin failures++; $display("[TB] FAIL pipe_we got=%0b%0b exp=10", WE, WEF); end
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("[TB] FAIL pipe_stall got=%0b exp=0", pipe_stall); end
        tick;
        // Float write to f0 is a normal write
        applyStimulus(1'b1, 5'd0, 32'h4000_0000, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (WEF !== 1'b1 || WE !== 1'b0 || WA !== 5'd0 || WB !== 32'h4000_0000) begin failures++;
            $display("[TB] FAIL pipe_f0 got=WEF%0b WE%0b WA%0d WB%0h exp=WEF1 WE0 WA0 WB40000000", WEF, WE, WA, WB); end
        tick;
        applyStimulus(1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (WE !== 1'b0 || WEF !== 1'b0) begin failures++; $display("[TB] FAIL pipe_x0 got=WE%0b WEF%0b exp=00", WE, WEF); end
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_fpu_write;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h3F80_0000, 1'b1);
        settle;
        checks++; if (fpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL fpu_ready got=%0b exp=1", fpu_ready); end
        checks++; if (WE !== 1'b0 || WEF !== 1'b0) begin failures++; $display("[TB] FAIL fpu_early got=WE%0b WEF%0b exp=00", WE, WEF); end
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (WA !== 5'd3 || WB !== 32'h3F80_0000) begin failures++; $display("[TB] FAIL fpu_wa_wb got=%0d/%0h exp=3/3f800000", WA, WB); end
        checks++; if (WEF !== 1'b1 || WE !== 1'b0) begin failures++; $display("[TB] FAIL fpu_wef got=WEF%0b WE%0b exp=10", WEF, WE); end
        checks++; if (fpu_pending !== 2'd1) begin failures++; $display("[TB] FAIL fpu_pending1 got=%0d exp=1", fpu_pending); end
        tick; settle;
        checks++; if (fpu_pending !== 2'd0 || WEF !== 1'b0) begin failures++; $display("[TB] FAIL fpu_drained got=pend%0d WEF%0b exp=pend0 WEF0", fpu_pending, WEF); end
        tick;
    endtask

    task automatic test_force;
        // Cycle 0: pipe wins, FPU entry accepted alongside
        applyStimulus(1'b1, 5'd9, 32'h0000_0100, 1'b0, 1'b1, 5'd7, 32'h0000_AAAA, 1'b0);
        settle;
        checks++; if (WB !== 32'h100 || WE !== 1'b1) begin failures++; $display("[TB] FAIL force_c0 got=WB%0h WE%0b exp=WB100 WE1", WB, WE); end
        tick;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'd9, 32'h100 + i, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            settle;
            checks++; if (WB !== 32'h100 + i || WA !== 5'd9 || pipe_stall !== 1'b0 || fpu_pending !== 2'd1) begin failures++;
                $display("[TB] FAIL force_pipe%0d got=WB%0h WA%0d stall%0b pend%0d exp=WB%0h WA9 stall0 pend1", i, WB, WA, pipe_stall, fpu_pending, 32'h100 + i); end
            tick;
        end
        applyStimulus(1'b1, 5'd9, 32'h0000_0105, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (pipe_stall !== 1'b1) begin failures++; $display("[TB] FAIL force_stall got=%0b exp=1", pipe_stall); end
        checks++; if (WA !== 5'd7 || WB !== 32'hAAAA || WE !== 1'b1) begin failures++; $display("[TB] FAIL force_fpu got=WA%0d WB%0h WE%0b exp=WA7 WBaaaa WE1", WA, WB, WE); end
        tick; settle;
        checks++; if (pipe_stall !== 1'b0 || WB !== 32'h105 || WA !== 5'd9 || fpu_pending !== 2'd0) begin failures++;
            $display("[TB] FAIL force_held got=stall%0b WB%0h WA%0d pend%0d exp=stall0 WB105 WA9 pend0", pipe_stall, WB, WA, fpu_pending); end
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b1, 5'd10, 32'h0000_0200, 1'b0, 1'b1, 5'd1, 32'hF000_0001, 1'b1);
        settle;
        checks++; if (fpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready0 got=%0b exp=1", fpu_ready); end
        tick;
        applyStimulus(1'b1, 5'd10, 32'h0000_0201, 1'b0, 1'b1, 5'd2, 32'hF000_0002, 1'b1);
        settle;
        checks++; if (fpu_ready !== 1'b1 || fpu_pending !== 2'd1) begin failures++; $display("[TB] FAIL b2b_ready1 got=rdy%0b pend%0d exp=rdy1 pend1", fpu_ready, fpu_pending); end
        tick;
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1'b1, 5'd10, 32'h200 + i, 1'b0, 1'b1, 5'd4, 32'hF000_0004, 1'b1);
            settle;
            checks++; if (fpu_ready !== 1'b0 || fpu_pending !== 2'd2 || WB !== 32'h200 + i) begin failures++;
                $display("[TB] FAIL b2b_full%0d got=rdy%0b pend%0d WB%0h exp=rdy0 pend2 WB%0h", i, fpu_ready, fpu_pending, WB, 32'h200 + i); end
            tick;
        end
        applyStimulus(1'b1, 5'd10, 32'h0000_0205, 1'b0, 1'b1, 5'd4, 32'hF000_0004, 1'b1);
        settle;
        checks++; if (pipe_stall !== 1'b1 || WA !== 5'd1 || WEF !== 1'b1 || fpu_ready !== 1'b0) begin failures++;
            $display("[TB] FAIL b2b_force got=stall%0b WA%0d WEF%0b rdy%0b exp=stall1 WA1 WEF1 rdy0", pipe_stall, WA, WEF, fpu_ready); end
        tick; settle;
        checks++; if (fpu_ready !== 1'b1 || fpu_pending !== 2'd1 || WB !== 32'h205 || pipe_stall !== 1'b0) begin failures++;
            $display("[TB] FAIL b2b_after got=rdy%0b pend%0d WB%0h stall%0b exp=rdy1 pend1 WB205 stall0", fpu_ready, fpu_pending, WB, pipe_stall); end
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (fpu_pending !== 2'd2 || WA !== 5'd2 || WB !== 32'hF000_0002) begin failures++;
            $display("[TB] FAIL b2b_drain2 got=pend%0d WA%0d WB%0h exp=pend2 WA2 WBf0000002", fpu_pending, WA, WB); end
        tick; settle;
        checks++; if (fpu_pending !== 2'd1 || WA !== 5'd4 || WB !== 32'hF000_0004) begin failures++;
            $display("[TB] FAIL b2b_drain3 got=pend%0d WA%0d WB%0h exp=pend1 WA4 WBf0000004", fpu_pending, WA, WB); end
        tick; settle;
        checks++; if (fpu_pending !== 2'd0 || WEF !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty got=pend%0d WEF%0b exp=pend0 WEF0", fpu_pending, WEF); end
        tick;
    endtask

    task automatic test_rd_zero_and_reset;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h0000_0055, 1'b0);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (fpu_pending !== 2'd1 || WE !== 1'b0 || WEF !== 1'b0) begin failures++;
            $display("[TB] FAIL x0_pop got=pend%0d WE%0b WEF%0b exp=pend1 WE0 WEF0", fpu_pending, WE, WEF); end
        tick; settle;
        checks++; if (fpu_pending !== 2'd0) begin failures++; $display("[TB] FAIL x0_consumed got=%0d exp=0", fpu_pending); end
        tick;
        applyStimulus(1'b1, 5'd11, 32'h300, 1'b0, 1'b1, 5'd12, 32'h0000_0C0C, 1'b0);
        tick;
        applyStimulus(1'b1, 5'd11, 32'h301, 1'b0, 1'b1, 5'd13, 32'h0000_0D0D, 1'b0);
        tick;
        applyStimulus(1'b1, 5'd11, 32'h302, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        settle;
        checks++; if (fpu_pending !== 2'd2) begin failures++; $display("[TB] FAIL rst_mid_pre got=%0d exp=2", fpu_pending); end
        rst = 1'b1;
        #1;
        checks++; if (fpu_pending !== 2'd0 || WE !== 1'b0 || WEF !== 1'b0 || fpu_ready !== 1'b0) begin failures++;
            $display("[TB] FAIL rst_mid got=pend%0d WE%0b WEF%0b rdy%0b exp=pend0 WE0 WEF0 rdy0", fpu_pending, WE, WEF, fpu_ready); end
        tick;
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick; settle;
        checks++; if (fpu_pending !== 2'd0 || WE !== 1'b0 || WEF !== 1'b0) begin failures++;
            $display("[TB] FAIL rst_mid_after got=pend%0d WE%0b WEF%0b exp=pend0 WE0 WEF0", fpu_pending, WE, WEF); end
        tick;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        test_reset;
        test_pipe_write;
        test_fpu_write;
        test_force;
        test_back_to_back;
        test_rd_zero_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
